// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: stall/exception/jump/branch redirects and halt detection.
// Optional MIPS branch-delay-slot behaviour is enabled by defining PC_DELAY_SLOT_EN.
module pc_sequencer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned OFFSET_W  = 16,
  parameter logic [31:0] RESET_VEC = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR = 32'h0,
  parameter int unsigned STEP      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                exc_en,
  input  logic [WIDTH-1:0]    exc_vec,
  input  logic                jump_en,
  input  logic [WIDTH-1:0]    jump_target,
  input  logic                branch_en,
  input  logic [OFFSET_W-1:0] branch_offset,
  output logic [WIDTH-1:0]    pc,
  output logic [WIDTH-1:0]    pc_next,
  output logic                active,
  output logic                redirect_pending
);

  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] HALT_PC  = WIDTH'(HALT_ADDR);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam int unsigned      EXT_W    = WIDTH - OFFSET_W;

  // HALTED encodes as zero so an unreset register file comes up halted at pc=0
  typedef enum logic {HALTED = 1'b0, RUN = 1'b1} state_t;

  state_t           state, nxt_state;
  logic [WIDTH-1:0] nxt_pc;
  logic [WIDTH-1:0] br_sext;
  logic [WIDTH-1:0] redir_target;
  logic             redirect;

`ifdef PC_DELAY_SLOT_EN
  logic             pending, nxt_pending;
  logic [WIDTH-1:0] pend_tgt, nxt_pend_tgt;
`endif

  assign br_sext      = {{EXT_W{branch_offset[OFFSET_W-1]}}, branch_offset};
  assign redir_target = jump_en ? jump_target : pc + br_sext;
  assign redirect     = jump_en | branch_en;

  // Next-state / next-pc selection; rst folded in so pc_next reflects it too
  always_comb begin
    nxt_state = state;
    nxt_pc    = pc;
`ifdef PC_DELAY_SLOT_EN
    nxt_pending  = pending;
    nxt_pend_tgt = pend_tgt;
`endif
    if (rst) begin
      nxt_state = RUN;
      nxt_pc    = RESET_PC;
`ifdef PC_DELAY_SLOT_EN
      nxt_pending = 1'b0;
`endif
    end else if (state == RUN && !stall) begin
`ifdef PC_DELAY_SLOT_EN
      if (exc_en) begin
        nxt_pc      = exc_vec;
        nxt_pending = 1'b0;
      end else if (pending) begin
        nxt_pc      = pend_tgt;
        nxt_pending = 1'b0;
      end else if (redirect) begin
        nxt_pc       = pc + STEP_W;
        nxt_pending  = 1'b1;
        nxt_pend_tgt = redir_target;
      end else begin
        nxt_pc = pc + STEP_W;
      end
`else
      if (exc_en)        nxt_pc = exc_vec;
      else if (redirect) nxt_pc = redir_target;
      else               nxt_pc = pc + STEP_W;
`endif
      if (nxt_pc == HALT_PC) begin
        nxt_state = HALTED;
`ifdef PC_DELAY_SLOT_EN
        nxt_pending = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
`ifdef PC_DELAY_SLOT_EN
      pending <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      pc    <= nxt_pc;
`ifdef PC_DELAY_SLOT_EN
      pending  <= nxt_pending;
      pend_tgt <= nxt_pend_tgt;
`endif
    end
  end

  assign pc_next = nxt_pc;
  assign active  = (state == RUN);
`ifdef PC_DELAY_SLOT_EN
  assign redirect_pending = pending;
`else
  assign redirect_pending = 1'b0;
`endif

endmodule
